// File: rtl/pov_pkg.sv
// -----------------------------------------------------------------------------
// pov_pkg
//   Shared types and defaults for the POV display string logic.
//   - state_t  : scanner FSM states
//   - *_DEF    : default character geometry
//   - cnt_w_f  : width needed to hold a count in the range 0..nchars
// -----------------------------------------------------------------------------
package pov_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int unsigned CHAR_W_DEF  = 11;
   localparam int unsigned NCHARS_DEF  = 7;
   localparam int unsigned DCHAR_W_DEF = 10;

   function automatic int unsigned cnt_w_f(input int unsigned nchars);
      return $clog2(nchars + 1);
   endfunction

endpackage

// File: rtl/string_null_scanner_if.sv
// -----------------------------------------------------------------------------
// string_null_scanner_if
//   Bundles the control-side signals of string_null_scanner.
//   master : drives String/Pattern/Mode/CompareString/DataChar, reads results
//   slave  : the scanner itself
//   Strings are packed with bit 0 as the MSB; slot i is bits
//   [i*CHAR_W : i*CHAR_W+CHAR_W-1].
// -----------------------------------------------------------------------------
interface string_null_scanner_if
   import pov_pkg::*;
#(
   parameter int unsigned CHAR_W  = CHAR_W_DEF,
   parameter int unsigned NCHARS  = NCHARS_DEF,
   parameter int unsigned DCHAR_W = DCHAR_W_DEF
);

   localparam int unsigned CNT_W = cnt_w_f(NCHARS);
   localparam int unsigned STR_W = CHAR_W * NCHARS;

   logic [0:STR_W-1]   String;
   logic [0:STR_W-1]   Pattern;
   logic               Mode;
   logic               CompareString;
   logic               Busy;
   logic               Done;
   logic               NullString;
   logic [CNT_W-1:0]   CharCount;
   logic [CNT_W-1:0]   FirstNullIdx;
   logic               Match;
   logic [DCHAR_W-1:0] DataChar;
   logic               NullDataChar;

   modport master (
      output String, Pattern, Mode, CompareString, DataChar,
      input  Busy, Done, NullString, CharCount, FirstNullIdx, Match, NullDataChar
   );

   modport slave (
      input  String, Pattern, Mode, CompareString, DataChar,
      output Busy, Done, NullString, CharCount, FirstNullIdx, Match, NullDataChar
   );

endinterface

// File: rtl/string_slot_select.sv
// -----------------------------------------------------------------------------
// string_slot_select
//   Combinational slot mux: returns slot[idx_i] of a packed string.
//   vec_i  : packed string, bit 0 = MSB, slot 0 at bits [0:CHAR_W-1]
//   idx_i  : slot index; out-of-range indices return zero
//   slot_o : selected slot, MSB first
// -----------------------------------------------------------------------------
module string_slot_select
   import pov_pkg::*;
#(
   parameter int unsigned CHAR_W = CHAR_W_DEF,
   parameter int unsigned NCHARS = NCHARS_DEF,
   parameter int unsigned CNT_W  = cnt_w_f(NCHARS_DEF)
) (
   input  logic [0:CHAR_W*NCHARS-1] vec_i,
   input  logic [CNT_W-1:0]         idx_i,
   output logic [CHAR_W-1:0]        slot_o
);

   always_comb begin
      slot_o = '0;
      for (int unsigned i = 0; i < NCHARS; i++) begin
         if (idx_i == CNT_W'(i)) begin
            slot_o = vec_i[i*CHAR_W +: CHAR_W];
         end
      end
   end

endmodule

// File: rtl/string_null_scanner.sv
// -----------------------------------------------------------------------------
// string_null_scanner
//   On a CompareString strobe (accepted in IDLE) snapshots String, Pattern
//   and Mode, then scans one slot per clock with a fixed NCHARS-cycle scan.
//   Results are registered in DONE together with a one-cycle Done pulse and
//   hold until the next Done or Reset.
//   Clock        : rising-edge system clock
//   Reset        : synchronous, active-high
//   bus (slave)  : String, Pattern, Mode, CompareString, DataChar in;
//                  Busy, Done, NullString, CharCount, FirstNullIdx, Match,
//                  NullDataChar out
//   NullDataChar is a registered (DataChar == 0), independent of the FSM.
// -----------------------------------------------------------------------------
module string_null_scanner
   import pov_pkg::*;
#(
   parameter int unsigned CHAR_W  = CHAR_W_DEF,
   parameter int unsigned NCHARS  = NCHARS_DEF,
   parameter int unsigned DCHAR_W = DCHAR_W_DEF
) (
   input logic                  Clock,
   input logic                  Reset,
   string_null_scanner_if.slave bus
);

   localparam int unsigned      CNT_W    = cnt_w_f(NCHARS);
   localparam int unsigned      STR_W    = CHAR_W * NCHARS;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NCHARS - 1);
   localparam logic [CNT_W-1:0] NCHARS_C = CNT_W'(NCHARS);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   idx_q, idx_d;
   logic [0:STR_W-1]   str_q, str_d;
   logic [0:STR_W-1]   pat_q, pat_d;
   logic               mode_q, mode_d;

   // scan accumulators
   logic               allzero_q, allzero_d;
   logic               seen_q, seen_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [CNT_W-1:0]   fnull_q, fnull_d;
   logic               eq_q, eq_d;

   // registered results
   logic               done_q, done_d;
   logic               nulls_q, nulls_d;
   logic [CNT_W-1:0]   charcnt_q, charcnt_d;
   logic [CNT_W-1:0]   fidx_q, fidx_d;
   logic               match_q, match_d;
   logic               ndc_q, ndc_d;

   logic [CHAR_W-1:0]  slot_s;
   logic [CHAR_W-1:0]  slot_p;

   string_slot_select #(
      .CHAR_W (CHAR_W),
      .NCHARS (NCHARS),
      .CNT_W  (CNT_W)
   ) u_sel_str (
      .vec_i  (str_q),
      .idx_i  (idx_q),
      .slot_o (slot_s)
   );

   string_slot_select #(
      .CHAR_W (CHAR_W),
      .NCHARS (NCHARS),
      .CNT_W  (CNT_W)
   ) u_sel_pat (
      .vec_i  (pat_q),
      .idx_i  (idx_q),
      .slot_o (slot_p)
   );

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      str_d     = str_q;
      pat_d     = pat_q;
      mode_d    = mode_q;
      allzero_d = allzero_q;
      seen_d    = seen_q;
      cnt_d     = cnt_q;
      fnull_d   = fnull_q;
      eq_d      = eq_q;
      done_d    = 1'b0;
      nulls_d   = nulls_q;
      charcnt_d = charcnt_q;
      fidx_d    = fidx_q;
      match_d   = match_q;

      unique case (state_q)
         IDLE: begin
            if (bus.CompareString) begin
               state_d   = SCAN;
               str_d     = bus.String;
               pat_d     = bus.Pattern;
               mode_d    = bus.Mode;
               idx_d     = '0;
               allzero_d = 1'b1;
               seen_d    = 1'b0;
               cnt_d     = '0;
               // stays at NCHARS when no zero slot turns up
               fnull_d   = NCHARS_C;
               eq_d      = 1'b1;
            end
         end
         SCAN: begin
            allzero_d = allzero_q & (slot_s == '0);
            if ((slot_s == '0) && !seen_q) begin
               fnull_d = idx_q;
               seen_d  = 1'b1;
            end
            if ((slot_s != '0) && !seen_q) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
            eq_d  = eq_q & (slot_s == slot_p);
            idx_d = idx_q + CNT_W'(1);
            if (idx_q == LAST_IDX) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d   = IDLE;
            done_d    = 1'b1;
            nulls_d   = allzero_q;
            charcnt_d = cnt_q;
            fidx_d    = fnull_q;
            match_d   = mode_q & eq_q;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign ndc_d = (bus.DataChar == '0);

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         str_q     <= '0;
         pat_q     <= '0;
         mode_q    <= 1'b0;
         allzero_q <= 1'b0;
         seen_q    <= 1'b0;
         cnt_q     <= '0;
         fnull_q   <= '0;
         eq_q      <= 1'b0;
         done_q    <= 1'b0;
         nulls_q   <= 1'b0;
         charcnt_q <= '0;
         fidx_q    <= '0;
         match_q   <= 1'b0;
         ndc_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         str_q     <= str_d;
         pat_q     <= pat_d;
         mode_q    <= mode_d;
         allzero_q <= allzero_d;
         seen_q    <= seen_d;
         cnt_q     <= cnt_d;
         fnull_q   <= fnull_d;
         eq_q      <= eq_d;
         done_q    <= done_d;
         nulls_q   <= nulls_d;
         charcnt_q <= charcnt_d;
         fidx_q    <= fidx_d;
         match_q   <= match_d;
         ndc_q     <= ndc_d;
      end
   end

   assign bus.Busy         = (state_q == SCAN);
   assign bus.Done         = done_q;
   assign bus.NullString   = nulls_q;
   assign bus.CharCount    = charcnt_q;
   assign bus.FirstNullIdx = fidx_q;
   assign bus.Match        = match_q;
   assign bus.NullDataChar = ndc_q;

endmodule

// File: tb/tb_string_null_scanner.sv
// -----------------------------------------------------------------------------
// tb_string_null_scanner
//   Table of directed scan vectors plus hand-written sequences for snapshot
//   semantics, mid-scan reset, back-to-back strobes and the DataChar path.
// -----------------------------------------------------------------------------
module tb_string_null_scanner;

   localparam int unsigned CW = 11;
   localparam int unsigned NC = 7;
   localparam int unsigned DW = 10;
   localparam int unsigned SW = CW * NC;

   typedef struct {
      logic [0:SW-1] str;
      logic [0:SW-1] pat;
      logic          mode;
      logic          exp_null;
      logic [2:0]    exp_cnt;
      logic [2:0]    exp_idx;
      logic          exp_match;
   } vec_t;

   logic clk;
   logic rst;
   int   pass_cnt;
   int   total_cnt;

   string_null_scanner_if #(.CHAR_W(CW), .NCHARS(NC), .DCHAR_W(DW)) bif ();

   string_null_scanner #(.CHAR_W(CW), .NCHARS(NC), .DCHAR_W(DW)) dut (
      .Clock (clk),
      .Reset (rst),
      .bus   (bif.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic logic [0:SW-1] mk(input logic [10:0] s0, s1, s2, s3, s4, s5, s6);
      logic [0:SW-1] r;
      r[0*CW +: CW] = s0;
      r[1*CW +: CW] = s1;
      r[2*CW +: CW] = s2;
      r[3*CW +: CW] = s3;
      r[4*CW +: CW] = s4;
      r[5*CW +: CW] = s5;
      r[6*CW +: CW] = s6;
      return r;
   endfunction

   task automatic run_scan(input logic [0:SW-1] s, input logic [0:SW-1] p, input logic m,
                           input logic en, input logic [2:0] ec, input logic [2:0] ei,
                           input logic em, input string tag);
      int cycles;
      @(negedge clk);
      bif.String = s; bif.Pattern = p; bif.Mode = m; bif.CompareString = 1'b1;
      @(negedge clk);
      bif.CompareString = 1'b0;
      chk({tag, "_busy"}, bif.Busy, 1);
      cycles = 0;
      while (!bif.Done && cycles < 20) begin
         @(negedge clk);
         cycles++;
      end
      chk({tag, "_latency"}, cycles, 8);
      chk({tag, "_busy_at_done"}, bif.Busy, 0);
      chk({tag, "_null"}, bif.NullString, en);
      chk({tag, "_cnt"}, bif.CharCount, ec);
      chk({tag, "_idx"}, bif.FirstNullIdx, ei);
      chk({tag, "_match"}, bif.Match, em);
   endtask

   vec_t          vecs [8];
   logic [0:SW-1] ones;
   logic [0:SW-1] flip;

   initial begin
      int dones;
      int d1;
      int d2;
      logic rn, rm;
      logic [2:0] rc, ri;

      pass_cnt = 0; total_cnt = 0;
      ones = '1;
      flip = ones;
      flip[6*CW] = ~flip[6*CW];

      vecs[0] = '{str: '0, pat: '0, mode: 1'b0,
                  exp_null: 1'b1, exp_cnt: 3'd0, exp_idx: 3'd0, exp_match: 1'b0};
      vecs[1] = '{str: mk(11'h041, 11'h042, 11'h043, 0, 0, 0, 0), pat: '0, mode: 1'b0,
                  exp_null: 1'b0, exp_cnt: 3'd3, exp_idx: 3'd3, exp_match: 1'b0};
      vecs[2] = '{str: ones, pat: ones, mode: 1'b1,
                  exp_null: 1'b0, exp_cnt: 3'd7, exp_idx: 3'd7, exp_match: 1'b1};
      vecs[3] = '{str: ones, pat: flip, mode: 1'b1,
                  exp_null: 1'b0, exp_cnt: 3'd7, exp_idx: 3'd7, exp_match: 1'b0};
      vecs[4] = '{str: mk(0, 11'h001, 0, 0, 0, 0, 0), pat: '0, mode: 1'b0,
                  exp_null: 1'b0, exp_cnt: 3'd0, exp_idx: 3'd0, exp_match: 1'b0};
      vecs[5] = '{str: ones, pat: ones, mode: 1'b0,
                  exp_null: 1'b0, exp_cnt: 3'd7, exp_idx: 3'd7, exp_match: 1'b0};
      vecs[6] = '{str: '0, pat: '0, mode: 1'b1,
                  exp_null: 1'b1, exp_cnt: 3'd0, exp_idx: 3'd0, exp_match: 1'b1};
      vecs[7] = '{str: mk(1, 2, 3, 4, 5, 0, 5), pat: mk(1, 2, 3, 4, 5, 0, 5), mode: 1'b1,
                  exp_null: 1'b0, exp_cnt: 3'd5, exp_idx: 3'd5, exp_match: 1'b1};

      // reset state
      rst = 1'b1;
      bif.String = '0; bif.Pattern = '0; bif.Mode = 1'b0;
      bif.CompareString = 1'b0; bif.DataChar = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy", bif.Busy, 0);
      chk("rst_done", bif.Done, 0);
      chk("rst_null", bif.NullString, 0);
      chk("rst_cnt", bif.CharCount, 0);
      chk("rst_idx", bif.FirstNullIdx, 0);
      chk("rst_match", bif.Match, 0);
      chk("rst_ndc", bif.NullDataChar, 0);
      rst = 1'b0;

      // DataChar path: one-cycle latency, forced low under reset
      bif.DataChar = '0;
      @(negedge clk); chk("ndc_0", bif.NullDataChar, 1); bif.DataChar = 10'h3FF;
      @(negedge clk); chk("ndc_3ff", bif.NullDataChar, 0); bif.DataChar = '0;
      @(negedge clk); chk("ndc_0b", bif.NullDataChar, 1);
      rst = 1'b1;
      @(negedge clk); chk("ndc_rst1", bif.NullDataChar, 0);
      @(negedge clk); chk("ndc_rst2", bif.NullDataChar, 0);
      rst = 1'b0;
      @(negedge clk); chk("ndc_rel", bif.NullDataChar, 1);

      // table-driven scans
      for (int i = 0; i < 8; i++) begin
         run_scan(vecs[i].str, vecs[i].pat, vecs[i].mode, vecs[i].exp_null,
                  vecs[i].exp_cnt, vecs[i].exp_idx, vecs[i].exp_match,
                  $sformatf("vec%0d", i));
      end

      // snapshot: inputs change and strobe repeats mid-scan
      @(negedge clk);
      bif.String = mk(0, 11'h001, 0, 0, 0, 0, 0); bif.Pattern = '0;
      bif.Mode = 1'b0; bif.CompareString = 1'b1;
      @(negedge clk);
      bif.CompareString = 1'b0;
      repeat (2) @(negedge clk);
      bif.String = '1; bif.Pattern = '1; bif.CompareString = 1'b1;
      @(negedge clk);
      bif.CompareString = 1'b0;
      chk("snap_hold_cnt", bif.CharCount, 5);
      chk("snap_hold_match", bif.Match, 1);
      dones = 0; rn = 1'b1; rm = 1'b1; rc = 3'd7; ri = 3'd7;
      repeat (15) begin
         @(negedge clk);
         if (bif.Done) begin
            dones++;
            rn = bif.NullString; rc = bif.CharCount; ri = bif.FirstNullIdx; rm = bif.Match;
         end
      end
      chk("snap_done_count", dones, 1);
      chk("snap_null", rn, 0);
      chk("snap_cnt", rc, 0);
      chk("snap_idx", ri, 0);
      chk("snap_match", rm, 0);
      bif.String = '0; bif.Pattern = '0;

      // reset mid-scan
      run_scan(ones, ones, 1'b1, 1'b0, 3'd7, 3'd7, 1'b1, "pre_rst");
      @(negedge clk);
      bif.String = ones; bif.Pattern = ones; bif.Mode = 1'b1; bif.CompareString = 1'b1;
      @(negedge clk);
      bif.CompareString = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mrst_busy", bif.Busy, 0);
      chk("mrst_done", bif.Done, 0);
      chk("mrst_null", bif.NullString, 0);
      chk("mrst_cnt", bif.CharCount, 0);
      chk("mrst_idx", bif.FirstNullIdx, 0);
      chk("mrst_match", bif.Match, 0);
      dones = 0;
      repeat (12) begin
         @(negedge clk);
         if (bif.Done) dones++;
      end
      chk("mrst_no_done", dones, 0);
      run_scan(vecs[1].str, '0, 1'b0, 1'b0, 3'd3, 3'd3, 1'b0, "post_rst");

      // strobe held high: back-to-back scans
      @(negedge clk);
      bif.String = vecs[1].str; bif.Mode = 1'b0; bif.CompareString = 1'b1;
      @(negedge clk);
      d1 = -1; d2 = -1;
      for (int t = 0; t < 40 && d2 < 0; t++) begin
         if (bif.Done) begin
            if (d1 < 0) d1 = t;
            else d2 = t;
         end
         if (d2 < 0) @(negedge clk);
      end
      bif.CompareString = 1'b0;
      chk("b2b_first_done", d1, 8);
      chk("b2b_second_done", d2, 17);
      chk("b2b_cnt", bif.CharCount, 3);
      repeat (12) @(negedge clk);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
